// File: rtl/pattern_driver_mc_if.sv
// Field-store, readback and pad-drive bundle for pattern_driver_mc.
// The master side writes fields and steers the pwm phase; the slave side returns registered drive and readback.
interface pattern_driver_mc_if #(
  parameter int WIDTH     = 8,
  parameter int NO_TWEAKS = 8,
  parameter int NO_BUFS   = 8
);
  localparam int NFIELDS = 2*NO_TWEAKS + 6;
  localparam int AW      = $clog2(NFIELDS);
  localparam int BSW     = (NO_BUFS > 1) ? $clog2(NO_BUFS) : 1;

  logic                       pwm;
  logic [AW-1:0]              field_addr;
  logic [WIDTH-1:0]           field_in;
  logic                       field_write;
  logic                       commit;
  logic [AW-1:0]              rd_addr;
  logic                       rd_shadow;
  logic [WIDTH-1:0]           field_byte_out;
  logic                       pending;
  logic [BSW-1:0]             buffer_select;
  logic                       dead;
  logic [WIDTH-1:0]           p_drive;
  logic [WIDTH-1:0]           n_drive;
  logic [WIDTH-1:0]           tweak_sense;
  logic [WIDTH-1:0]           tweak_delay;
  logic [WIDTH*NO_TWEAKS-1:0] tweak_drive;

  modport master (
    output pwm, field_addr, field_in, field_write, commit, rd_addr, rd_shadow,
    input  field_byte_out, pending, buffer_select, dead, p_drive, n_drive,
           tweak_sense, tweak_delay, tweak_drive
  );

  modport slave (
    input  pwm, field_addr, field_in, field_write, commit, rd_addr, rd_shadow,
    output field_byte_out, pending, buffer_select, dead, p_drive, n_drive,
           tweak_sense, tweak_delay, tweak_drive
  );
endinterface

// File: rtl/pattern_driver_mc.sv
// Shadow/active drive-field store with pwm-edge commit, dead-time and phase-selected pad outputs.
// All outputs are registered one clk after their inputs; no backpressure, one update per clk.
module pattern_driver_mc #(
  parameter int WIDTH       = 8,
  parameter int NO_TWEAKS   = 8,
  parameter int NO_BUFS     = 8,
  parameter int DEAD_CYCLES = 2,
  parameter int GATE_SENSE  = 0
) (
  input logic              clk,
  input logic              rst,
  pattern_driver_mc_if.slave bus
);
  localparam int NFIELDS  = 2*NO_TWEAKS + 6;
  localparam int AW       = $clog2(NFIELDS);
  localparam int BSW      = (NO_BUFS > 1) ? $clog2(NO_BUFS) : 1;
  localparam int DCW      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int NBASE    = 4 + NO_TWEAKS;
  localparam int BS_MAX_I = NO_BUFS - 1;
  localparam int DC_LD_I  = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
  localparam logic [AW:0]     NF_LIM  = NFIELDS[AW:0];
  localparam logic [BSW-1:0]  BS_MAX  = BS_MAX_I[BSW-1:0];
  localparam logic [DCW-1:0]  DC_LOAD = DC_LD_I[DCW-1:0];

  logic [WIDTH-1:0]           shadow [NFIELDS];
  logic [WIDTH-1:0]           active [NFIELDS];
  logic                       pwm_prev;
  logic [DCW-1:0]             dead_cnt;
  logic                       edge_det;
  logic                       off;
  logic                       do_copy;
  logic                       wr_ok;
  logic [WIDTH-1:0]           sel_sense;
  logic [WIDTH-1:0]           sel_delay;
  logic [WIDTH-1:0]           gate_mask;
  logic [WIDTH*NO_TWEAKS-1:0] sel_tweak;

  assign edge_det = bus.pwm != pwm_prev;
  assign off      = (DEAD_CYCLES > 0) && (edge_det || dead_cnt != '0);
  assign do_copy  = edge_det && (bus.pending || bus.commit);
  assign wr_ok    = bus.field_write && ({1'b0, bus.field_addr} < NF_LIM);

  // P and N field groups share the same layout, offset by NBASE-2.
  always_comb begin
    sel_sense = pwm_prev ? active[2] : active[NBASE];
    sel_delay = pwm_prev ? active[3] : active[NBASE+1];
    gate_mask = (GATE_SENSE != 0) ? ~(sel_sense ^ {WIDTH{pwm_prev}}) : '1;
    sel_tweak = '0;
    for (int k = 0; k < NO_TWEAKS; k++) begin
      sel_tweak[k*WIDTH +: WIDTH] = (pwm_prev ? active[4+k] : active[NBASE+2+k]) & gate_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NFIELDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pwm_prev          <= 1'b0;
      dead_cnt          <= '0;
      bus.pending       <= 1'b0;
      bus.buffer_select <= BS_MAX;
    end else begin
      pwm_prev <= bus.pwm;
      if (edge_det)
        bus.buffer_select <= '0;
      else if (bus.buffer_select != BS_MAX)
        bus.buffer_select <= bus.buffer_select + 1'b1;
      if (edge_det)
        dead_cnt <= DC_LOAD;
      else if (dead_cnt != '0)
        dead_cnt <= dead_cnt - 1'b1;
      // Copy takes the pre-write shadow when a write lands in the same cycle.
      if (do_copy) begin
        for (int i = 0; i < NFIELDS; i++) active[i] <= shadow[i];
        bus.pending <= 1'b0;
      end else if (bus.commit) begin
        bus.pending <= 1'b1;
      end
      if (wr_ok) shadow[bus.field_addr] <= bus.field_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dead           <= 1'b0;
      bus.p_drive        <= '1;
      bus.n_drive        <= '0;
      bus.tweak_sense    <= '0;
      bus.tweak_delay    <= '0;
      bus.tweak_drive    <= '0;
      bus.field_byte_out <= '0;
    end else begin
      bus.dead <= off;
      if (off) begin
        bus.p_drive     <= '1;
        bus.n_drive     <= '0;
        bus.tweak_drive <= '0;
      end else begin
        bus.p_drive     <= pwm_prev ? active[0] : '1;
        bus.n_drive     <= pwm_prev ? '0 : active[1];
        bus.tweak_sense <= sel_sense;
        bus.tweak_delay <= sel_delay;
        bus.tweak_drive <= sel_tweak;
      end
      if ({1'b0, bus.rd_addr} < NF_LIM)
        bus.field_byte_out <= bus.rd_shadow ? shadow[bus.rd_addr] : active[bus.rd_addr];
      else
        bus.field_byte_out <= '0;
    end
  end
endmodule

// File: tb/tb_pattern_driver_mc.sv
// Randomised and directed bench for pattern_driver_mc across three dead-time / sense-gating builds.
module tb_pattern_driver_mc;
  localparam int W  = 8;
  localparam int T  = 8;
  localparam int NB = 8;
  localparam int NF = 2*T + 6;
  localparam int AW = $clog2(NF);
  localparam int NI = 3;
  localparam bit [2:0][3:0] DCP = {4'd1, 4'd0, 4'd2};
  localparam bit [2:0][3:0] GSP = {4'd1, 4'd0, 4'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          pwm = 1'b0;
  logic [AW-1:0] field_addr = '0;
  logic [W-1:0]  field_in = '0;
  logic          field_write = 1'b0;
  logic          commit = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_shadow = 1'b0;

  logic [W-1:0]   o_rb [NI], o_p [NI], o_n [NI], o_s [NI], o_d [NI];
  logic [W*T-1:0] o_tw [NI];
  logic           o_pend [NI], o_dead [NI];
  logic [2:0]     o_bs [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pattern_driver_mc_if #(.WIDTH(W), .NO_TWEAKS(T), .NO_BUFS(NB)) bus ();
    assign bus.pwm         = pwm;
    assign bus.field_addr  = field_addr;
    assign bus.field_in    = field_in;
    assign bus.field_write = field_write;
    assign bus.commit      = commit;
    assign bus.rd_addr     = rd_addr;
    assign bus.rd_shadow   = rd_shadow;
    assign o_rb[g]   = bus.field_byte_out;
    assign o_pend[g] = bus.pending;
    assign o_bs[g]   = bus.buffer_select;
    assign o_dead[g] = bus.dead;
    assign o_p[g]    = bus.p_drive;
    assign o_n[g]    = bus.n_drive;
    assign o_s[g]    = bus.tweak_sense;
    assign o_d[g]    = bus.tweak_delay;
    assign o_tw[g]   = bus.tweak_drive;
    pattern_driver_mc #(.WIDTH(W), .NO_TWEAKS(T), .NO_BUFS(NB),
                        .DEAD_CYCLES(int'(DCP[g])), .GATE_SENSE(int'(GSP[g])))
      dut (.clk(clk), .rst(rst), .bus(bus));
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: field arrays plus "cycles since last pwm edge".
  logic [W-1:0]  sh [NF], ac [NF];
  logic          pp, pend;
  int            since, e_bs;
  logic [W-1:0]  e_rb;
  logic [W-1:0]  e_p [NI], e_n [NI], e_s [NI], e_d [NI];
  logic [63:0]   e_tw [NI];
  logic          e_dead [NI];

  function automatic int dc(input int g);
    return int'(DCP[g]);
  endfunction

  function automatic int gs(input int g);
    return int'(GSP[g]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      sh[i] = '0;
      ac[i] = '0;
    end
    pp = 1'b0; pend = 1'b0; since = 1000; e_bs = NB-1; e_rb = '0;
    for (int g = 0; g < NI; g++) begin
      e_p[g] = 8'hFF; e_n[g] = '0; e_s[g] = '0; e_d[g] = '0; e_tw[g] = '0; e_dead[g] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic edge_m, off;
    logic [W-1:0] mask;
    int base;
    edge_m = (pwm != pp);
    if (edge_m) since = 0;
    else if (since < 1000) since++;
    e_bs = (since > NB-1) ? NB-1 : since;
    e_rb = (int'(rd_addr) < NF) ? (rd_shadow ? sh[rd_addr] : ac[rd_addr]) : '0;
    for (int g = 0; g < NI; g++) begin
      off = (dc(g) > 0) && (since < dc(g));
      e_dead[g] = off;
      if (off) begin
        e_p[g] = 8'hFF; e_n[g] = '0; e_tw[g] = '0;
      end else begin
        base = pp ? 2 : 4 + T;
        e_s[g] = ac[base];
        e_d[g] = ac[base+1];
        for (int b = 0; b < W; b++) mask[b] = (gs(g) == 0) || (ac[base][b] == pp);
        for (int k = 0; k < T; k++) e_tw[g][k*W +: W] = ac[base+2+k] & mask;
        e_p[g] = pp ? ac[0] : 8'hFF;
        e_n[g] = pp ? 8'h00 : ac[1];
      end
    end
    if (edge_m && (pend || commit)) begin
      ac = sh;
      pend = 1'b0;
    end else if (commit) begin
      pend = 1'b1;
    end
    if (field_write && int'(field_addr) < NF) sh[field_addr] = field_in;
    pp = pwm;
  endtask

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("dead%0d", g), 64'(o_dead[g]), 64'(e_dead[g]));
      check($sformatf("p_drive%0d", g), 64'(o_p[g]), 64'(e_p[g]));
      check($sformatf("n_drive%0d", g), 64'(o_n[g]), 64'(e_n[g]));
      check($sformatf("sense%0d", g), 64'(o_s[g]), 64'(e_s[g]));
      check($sformatf("delay%0d", g), 64'(o_d[g]), 64'(e_d[g]));
      check($sformatf("tweaks%0d", g), 64'(o_tw[g]), e_tw[g]);
      check($sformatf("bufsel%0d", g), 64'(o_bs[g]), 64'(e_bs));
      check($sformatf("pending%0d", g), 64'(o_pend[g]), 64'(pend));
      check($sformatf("readback%0d", g), 64'(o_rb[g]), 64'(e_rb));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    field_write = 1'b1;
    field_addr  = AW'(a);
    field_in    = d;
    tick();
    field_write = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;

    // Shadow write + commit held until a pwm edge
    wr(0, 8'h5A);
    commit = 1'b1; tick(); commit = 1'b0; tick();
    check("t1_pending", 64'(o_pend[0]), 64'd1);
    rd_addr = '0; rd_shadow = 1'b0; tick();
    check("t1_active0_old", 64'(o_rb[0]), 64'h0);
    check("t1_p_off", 64'(o_p[0]), 64'hFF);
    check("t1_n_zero", 64'(o_n[0]), 64'h0);
    pwm = 1'b1; tick();
    check("t1_pending_clr", 64'(o_pend[0]), 64'd0);
    tick();
    check("t1_active0_new", 64'(o_rb[0]), 64'h5A);

    // Dead time and buffer_select after an edge
    wr(0, 8'h3C); wr(1, 8'hC3);
    commit = 1'b1; pwm = 1'b0; tick(); commit = 1'b0;
    repeat (9) tick();
    check("t2_n_before", 64'(o_n[0]), 64'hC3);
    pwm = 1'b1; tick();
    check("t2_dead_a", 64'(o_dead[0]), 64'd1);
    check("t2_p_off_a", 64'(o_p[0]), 64'hFF);
    check("t2_bs0", 64'(o_bs[0]), 64'd0);
    check("t3_old_phase", 64'(o_n[1]), 64'hC3);
    check("t3_no_dead", 64'(o_dead[1]), 64'd0);
    tick();
    check("t2_dead_b", 64'(o_dead[0]), 64'd1);
    check("t3_p_new", 64'(o_p[1]), 64'h3C);
    tick();
    check("t2_dead_end", 64'(o_dead[0]), 64'd0);
    check("t2_p_on", 64'(o_p[0]), 64'h3C);
    check("t2_n_off", 64'(o_n[0]), 64'h0);
    repeat (5) tick();
    check("t2_bs7", 64'(o_bs[0]), 64'd7);
    repeat (3) tick();
    check("t2_bs_hold", 64'(o_bs[0]), 64'd7);

    // Second edge inside dead time restarts the count
    pwm = 1'b0; tick();
    pwm = 1'b1; tick();
    check("t4_dead_a", 64'(o_dead[0]), 64'd1);
    check("t4_bs0", 64'(o_bs[0]), 64'd0);
    tick();
    check("t4_dead_b", 64'(o_dead[0]), 64'd1);
    tick();
    check("t4_dead_end", 64'(o_dead[0]), 64'd0);

    // Sense gating and an out-of-range write
    wr(2, 8'h0F); wr(4, 8'hFF);
    commit = 1'b1; pwm = 1'b0; tick(); commit = 1'b0;
    pwm = 1'b1; tick();
    repeat (3) tick();
    check("t5_gated", 64'(o_tw[2][7:0]), 64'h0F);
    check("t5_ungated", 64'(o_tw[0][7:0]), 64'hFF);
    wr(23, 8'hAA);
    rd_addr = AW'(23); rd_shadow = 1'b1; tick();
    check("t5_rb_oor", 64'(o_rb[0]), 64'h0);

    // Write, commit and edge all in one cycle
    field_write = 1'b1; field_addr = '0; field_in = 8'h77; commit = 1'b1; pwm = 1'b0;
    tick();
    field_write = 1'b0; commit = 1'b0;
    rd_addr = '0; rd_shadow = 1'b0; tick();
    check("t6_active_old", 64'(o_rb[0]), 64'h3C);
    check("t6_pending", 64'(o_pend[0]), 64'd0);
    rd_shadow = 1'b1; tick();
    check("t6_shadow_new", 64'(o_rb[0]), 64'h77);

    // Random traffic with an asynchronous reset midway
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) pwm = ~pwm;
      field_write = 1'($urandom_range(0, 1));
      field_addr  = AW'($urandom_range(0, 27));
      field_in    = W'($urandom);
      commit      = ($urandom_range(0, 7) == 0);
      rd_addr     = AW'($urandom_range(0, 31));
      rd_shadow   = 1'($urandom_range(0, 1));
      tick();
      if (i == 750) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
